// File: rtl/rv32i_types.sv
// Shared RV32I types: store-buffer entry layout and the store-drain FSM states.
package rv32i_types;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } sb_entry_t;

  typedef enum logic [1:0] {
    SD_IDLE,
    SD_REQ,
    SD_WAIT
  } store_drain_state_t;

endpackage

// File: rtl/store_drain_unit.sv
// Drains retired stores from the store-queue head to the D-cache arbiter, in order and exactly once.
// Optional perf counters are enabled by defining STORE_DRAIN_PERF_EN.
module store_drain_unit
  import rv32i_types::*;
#(
  parameter int SQ_DEPTH_BITS = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  sb_entry_t                sq_head,
  input  logic [SQ_DEPTH_BITS:0]   sq_elemcount,
  output logic                     sq_dequeue,
  input  logic                     commit_store,
  output logic                     dmem_wr_req,
  input  logic                     dmem_wr_gnt,
  input  logic                     dmem_wr_resp,
  output logic [31:0]              dmem_addr,
  output logic [3:0]               dmem_wmask,
  output logic [31:0]              dmem_wdata,
  output logic [SQ_DEPTH_BITS:0]   pending_commits,
  output logic                     drain_busy
`ifdef STORE_DRAIN_PERF_EN
  ,
  output logic [31:0]              perf_stores_drained,
  output logic [31:0]              perf_stall_cycles
`endif
);

  localparam logic [SQ_DEPTH_BITS:0] PENDING_MAX = {1'b1, {SQ_DEPTH_BITS{1'b0}}};

  store_drain_state_t state;
  sb_entry_t          entry;

  // Dequeue only ever accompanies a write response, so a store leaves the queue exactly once.
  always_comb begin
    sq_dequeue  = dmem_wr_resp && ((state == SD_WAIT) || (state == SD_REQ && dmem_wr_gnt));
    dmem_wr_req = (state == SD_REQ);
    drain_busy  = (state != SD_IDLE);
    dmem_addr   = drain_busy ? {entry.addr[31:2], 2'b00} : '0;
    dmem_wdata  = drain_busy ? entry.wdata : '0;
    dmem_wmask  = drain_busy ? entry.wmask : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= SD_IDLE;
      entry           <= '0;
      pending_commits <= '0;
    end else begin
      pending_commits <= pending_commits
                         + {{SQ_DEPTH_BITS{1'b0}}, commit_store}
                         - {{SQ_DEPTH_BITS{1'b0}}, sq_dequeue};
      case (state)
        SD_IDLE: begin
          if (pending_commits != '0 && sq_elemcount != '0) begin
            entry <= sq_head;
            state <= SD_REQ;
          end
        end
        SD_REQ: begin
          if (dmem_wr_gnt) begin
            state <= dmem_wr_resp ? SD_IDLE : SD_WAIT;
          end
        end
        SD_WAIT: begin
          if (dmem_wr_resp) begin
            state <= SD_IDLE;
          end
        end
        default: state <= SD_IDLE;
      endcase
    end
  end

  // The head must not move while its write is in flight, and the commit count never wraps.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(commit_store && !sq_dequeue && pending_commits == PENDING_MAX));
      assert (!(sq_dequeue && !commit_store && pending_commits == '0));
      assert (!(state == SD_WAIT && entry.addr != sq_head.addr));
    end
  end

`ifdef STORE_DRAIN_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stores_drained <= '0;
      perf_stall_cycles   <= '0;
    end else begin
      if (sq_dequeue) perf_stores_drained <= perf_stores_drained + 32'd1;
      if (state == SD_REQ && !dmem_wr_gnt) perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_store_drain_unit.sv
// Table-driven bench for store_drain_unit with a small store-queue model feeding sq_head.
// Perf counter checks are compiled in when STORE_DRAIN_PERF_EN is defined.
module tb_store_drain_unit;
  import rv32i_types::*;

  localparam int DB = 3;

  logic            clk;
  logic            rst;
  sb_entry_t       sq_head;
  logic [DB:0]     sq_elemcount;
  logic            sq_dequeue;
  logic            commit_store;
  logic            dmem_wr_req;
  logic            dmem_wr_gnt;
  logic            dmem_wr_resp;
  logic [31:0]     dmem_addr;
  logic [3:0]      dmem_wmask;
  logic [31:0]     dmem_wdata;
  logic [DB:0]     pending_commits;
  logic            drain_busy;
`ifdef STORE_DRAIN_PERF_EN
  logic [31:0]     perf_stores_drained;
  logic [31:0]     perf_stall_cycles;
`endif

  store_drain_unit #(.SQ_DEPTH_BITS(DB)) dut (
    .clk             (clk),
    .rst             (rst),
    .sq_head         (sq_head),
    .sq_elemcount    (sq_elemcount),
    .sq_dequeue      (sq_dequeue),
    .commit_store    (commit_store),
    .dmem_wr_req     (dmem_wr_req),
    .dmem_wr_gnt     (dmem_wr_gnt),
    .dmem_wr_resp    (dmem_wr_resp),
    .dmem_addr       (dmem_addr),
    .dmem_wmask      (dmem_wmask),
    .dmem_wdata      (dmem_wdata),
    .pending_commits (pending_commits),
    .drain_busy      (drain_busy)
`ifdef STORE_DRAIN_PERF_EN
    ,
    .perf_stores_drained (perf_stores_drained),
    .perf_stall_cycles   (perf_stall_cycles)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int push_idx;
    bit commit;
    bit gnt;
    bit resp;
    bit req;
    bit deq;
    int pend;
    bit busy;
    int out_idx;
  } vec_t;

  sb_entry_t ent [10];
  sb_entry_t sq_model [$];
  vec_t      vecs [$];
  int        total_checks = 0;
  int        passed_checks = 0;
  int        cyc = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total_checks++;
    if (actual === expected) passed_checks++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  task automatic add_vec(input int p, input bit c, input bit g, input bit r,
                         input bit req, input bit deq, input int pend, input bit busy, input int o);
    vec_t v;
    v.push_idx = p; v.commit = c; v.gnt = g; v.resp = r;
    v.req = req; v.deq = deq; v.pend = pend; v.busy = busy; v.out_idx = o;
    vecs.push_back(v);
  endtask

  task automatic refresh_head();
    sq_head      = (sq_model.size() > 0) ? sq_model[0] : '0;
    sq_elemcount = (DB + 1)'(sq_model.size());
  endtask

  // One clock: drive inputs, compare at the falling edge, then advance the queue model.
  task automatic applyStimulus(input int p, input bit c, input bit g, input bit r, input bit rs,
                               input bit req, input bit deq, input int pend, input bit busy,
                               input int o, input string tag);
    logic [31:0] ea, ew;
    logic [3:0]  em;
    bit          d;
    commit_store = c; dmem_wr_gnt = g; dmem_wr_resp = r; rst = rs;
    @(negedge clk);
    ea = (o < 0) ? 32'h0 : (ent[o].addr & ~32'h3);
    ew = (o < 0) ? 32'h0 : ent[o].wdata;
    em = (o < 0) ? 4'h0 : ent[o].wmask;
    check($sformatf("%s c%0d req", tag, cyc), {31'b0, dmem_wr_req}, {31'b0, req});
    check($sformatf("%s c%0d deq", tag, cyc), {31'b0, sq_dequeue}, {31'b0, deq});
    check($sformatf("%s c%0d pending", tag, cyc), 32'(pending_commits), 32'(pend));
    check($sformatf("%s c%0d busy", tag, cyc), {31'b0, drain_busy}, {31'b0, busy});
    check($sformatf("%s c%0d addr", tag, cyc), dmem_addr, ea);
    check($sformatf("%s c%0d wdata", tag, cyc), dmem_wdata, ew);
    check($sformatf("%s c%0d wmask", tag, cyc), {28'b0, dmem_wmask}, {28'b0, em});
    d = sq_dequeue;
    @(posedge clk);
    #1;
    if (rs) sq_model.delete();
    else begin
      if (d && sq_model.size() > 0) void'(sq_model.pop_front());
      if (p >= 0) sq_model.push_back(ent[p]);
    end
    refresh_head();
    cyc++;
  endtask

  task automatic checkOutput(input logic [31:0] drained, input logic [31:0] stalls, input string tag);
`ifdef STORE_DRAIN_PERF_EN
    check({tag, " perf_stores_drained"}, perf_stores_drained, drained);
    check({tag, " perf_stall_cycles"}, perf_stall_cycles, stalls);
`else
    $display("[TB] %s: perf counters not built (expected %0d drains, %0d stalls)", tag, drained, stalls);
`endif
  endtask

  initial begin
    ent[0] = '{addr: 32'h1000_0004, wdata: 32'hDEAD_BEEF, wmask: 4'b1111};
    ent[1] = '{addr: 32'h0000_0100, wdata: 32'h1111_1111, wmask: 4'b0001};
    ent[2] = '{addr: 32'h0000_0104, wdata: 32'h2222_2222, wmask: 4'b0011};
    ent[3] = '{addr: 32'h0000_0108, wdata: 32'h3333_3333, wmask: 4'b1100};
    ent[4] = '{addr: 32'h0000_010C, wdata: 32'h4444_4444, wmask: 4'b1000};
    ent[5] = '{addr: 32'h2000_0000, wdata: 32'hA5A5_A5A5, wmask: 4'b0110};
    ent[6] = '{addr: 32'h2000_0013, wdata: 32'h5A5A_5A5A, wmask: 4'b1000};
    ent[7] = '{addr: 32'h3000_0000, wdata: 32'hCAFE_F00D, wmask: 4'b1111};
    ent[8] = '{addr: 32'h3000_0004, wdata: 32'h0BAD_CAFE, wmask: 4'b1111};
    ent[9] = '{addr: 32'h4000_0008, wdata: 32'h1234_5678, wmask: 4'b0101};

    // Commit gating, then a slow handshake (grant after 3 REQ cycles, response 4 after grant).
    add_vec(0, 0,0,0, 0,0,0,0,-1);
    for (int i = 0; i < 10; i++) add_vec(-1, 0,0,0, 0,0,0,0,-1);
    add_vec(-1, 1,0,0, 0,0,0,0,-1);
    add_vec(-1, 0,0,0, 0,0,1,0,-1);
    for (int i = 0; i < 3; i++) add_vec(-1, 0,0,0, 1,0,1,1,0);
    add_vec(-1, 0,1,0, 1,0,1,1,0);
    for (int i = 0; i < 3; i++) add_vec(-1, 0,0,0, 0,0,1,1,0);
    add_vec(-1, 0,0,1, 0,1,1,1,0);
    // Back-to-back drains of four consecutively committed stores.
    for (int i = 1; i <= 4; i++) add_vec(i, 0,0,0, 0,0,0,0,-1);
    add_vec(-1, 1,1,0, 0,0,0,0,-1);
    add_vec(-1, 1,1,0, 0,0,1,0,-1);
    add_vec(-1, 1,1,0, 1,0,2,1,1);
    add_vec(-1, 1,1,1, 0,1,3,1,1);
    add_vec(-1, 0,1,0, 0,0,3,0,-1);
    add_vec(-1, 0,1,0, 1,0,3,1,2);
    add_vec(-1, 0,1,1, 0,1,3,1,2);
    add_vec(-1, 0,1,0, 0,0,2,0,-1);
    add_vec(-1, 0,1,0, 1,0,2,1,3);
    add_vec(-1, 0,1,1, 0,1,2,1,3);
    add_vec(-1, 0,1,0, 0,0,1,0,-1);
    add_vec(-1, 0,1,0, 1,0,1,1,4);
    add_vec(-1, 0,1,1, 0,1,1,1,4);
    // Commit coinciding with dequeue, then same-cycle grant+response on an unaligned address.
    add_vec(5, 0,0,0, 0,0,0,0,-1);
    add_vec(6, 0,0,0, 0,0,0,0,-1);
    add_vec(-1, 1,0,0, 0,0,0,0,-1);
    add_vec(-1, 0,0,0, 0,0,1,0,-1);
    add_vec(-1, 0,1,0, 1,0,1,1,5);
    add_vec(-1, 1,0,1, 0,1,1,1,5);
    add_vec(-1, 0,0,0, 0,0,1,0,-1);
    add_vec(-1, 0,1,1, 1,1,1,1,6);
    add_vec(-1, 0,0,0, 0,0,0,0,-1);

    rst = 1'b1; commit_store = 1'b0; dmem_wr_gnt = 1'b0; dmem_wr_resp = 1'b0;
    sq_head = '0; sq_elemcount = '0;
    @(posedge clk);
    #1;
    applyStimulus(-1, 0,0,0,1, 0,0,0,0,-1, "reset");
    cyc = 0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].push_idx, vecs[i].commit, vecs[i].gnt, vecs[i].resp, 1'b0,
                    vecs[i].req, vecs[i].deq, vecs[i].pend, vecs[i].busy, vecs[i].out_idx, "vec");
    end
    checkOutput(32'd7, 32'd3, "after table");

    // Reset while a write is in WAIT, then commits that arrive before their queue entry.
    applyStimulus(7, 1,0,0,0, 0,0,0,0,-1, "rstwait");
    applyStimulus(8, 1,0,0,0, 0,0,1,0,-1, "rstwait");
    applyStimulus(-1, 0,1,0,0, 1,0,2,1,7, "rstwait");
    applyStimulus(-1, 0,0,0,1, 0,0,2,1,7, "rstwait");
    applyStimulus(-1, 0,0,0,0, 0,0,0,0,-1, "rstwait");
    applyStimulus(-1, 1,0,0,0, 0,0,0,0,-1, "emptyq");
    applyStimulus(-1, 0,0,0,0, 0,0,1,0,-1, "emptyq");
    applyStimulus(9, 0,0,0,0, 0,0,1,0,-1, "emptyq");
    applyStimulus(-1, 0,0,0,0, 0,0,1,0,-1, "emptyq");
    applyStimulus(-1, 0,0,0,0, 1,0,1,1,9, "emptyq");
    applyStimulus(-1, 0,1,1,0, 1,1,1,1,9, "emptyq");
    applyStimulus(-1, 0,0,0,0, 0,0,0,0,-1, "emptyq");
    checkOutput(32'd1, 32'd1, "after reset");

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
